// File: rtl/cpu6_hazard_ctrl.sv
// cpu6_hazard_ctrl: pipeline stall/flush sequencing for the 5-stage cpu6 core.
// Handles load-use, MEM redirects, data-memory waits with timeout and CSR drain.
//
// Ports:
//   clk, reset (async, active-low)
//   rs1D/rs2D, rs1_useD/rs2_useD     : ID operand indices and use flags
//   writeregE, regwriteE, memtoregE  : EX destination, write enable, load flag
//   csr_wr_enE                       : EX instruction writes a CSR
//   redirectM, memwriteM, memtoregM  : MEM redirect, store and load flags
//   dmem_ready / dmem_req            : data memory handshake
//   stallF/D/E/M, flushD/E/M/W       : per-register hold / bubble enables
//   mem_timeout_err                  : one-cycle pulse on memory timeout
//   state_o                          : FSM state (debug)
module cpu6_hazard_ctrl #(
    parameter int RFIDX_WIDTH = 5,
    parameter int CNT_WIDTH   = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int CSR_DRAIN   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RFIDX_WIDTH-1:0] rs1D,
    input  logic [RFIDX_WIDTH-1:0] rs2D,
    input  logic                   rs1_useD,
    input  logic                   rs2_useD,
    input  logic [RFIDX_WIDTH-1:0] writeregE,
    input  logic                   regwriteE,
    input  logic                   memtoregE,
    input  logic                   csr_wr_enE,
    input  logic                   redirectM,
    input  logic                   memwriteM,
    input  logic                   memtoregM,
    input  logic                   dmem_ready,
    output logic                   dmem_req,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   stallM,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   flushM,
    output logic                   flushW,
    output logic                   mem_timeout_err,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MEM_WAIT  = 2'd1,
        S_CSR_DRAIN = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] DRAIN_C   = CNT_WIDTH'(CSR_DRAIN);
    localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic memop;
    logic lu_hazard;
    logic req_c, err_c;
    logic sf_c, sd_c, se_c, sm_c;
    logic fd_c, fe_c, fm_c, fw_c;

    assign memop = memwriteM | memtoregM;

    assign lu_hazard = memtoregE & regwriteE & (writeregE != '0)
                     & ((rs1_useD & (rs1D == writeregE))
                      | (rs2_useD & (rs2D == writeregE)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        err_c   = 1'b0;
        sf_c    = 1'b0;
        sd_c    = 1'b0;
        se_c    = 1'b0;
        sm_c    = 1'b0;
        fd_c    = 1'b0;
        fe_c    = 1'b0;
        fm_c    = 1'b0;
        fw_c    = 1'b0;
        case (state_q)
            S_MEM_WAIT: begin
                req_c = memop;
                if (dmem_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= TIMEOUT_C) begin
                    // Give up: drop the MEM instruction and let the pipe move.
                    req_c   = 1'b0;
                    err_c   = 1'b1;
                    fw_c    = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    {sf_c, sd_c, se_c, sm_c} = 4'hf;
                    fw_c  = 1'b1;
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_CSR_DRAIN: begin
                sf_c = 1'b1;
                sd_c = 1'b1;
                fe_c = 1'b1;
                if (cnt_q <= ONE_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            default: begin
                // Idle; encoding 3 also lands here.
                req_c = memop;
                if (memop && !dmem_ready) begin
                    {sf_c, sd_c, se_c, sm_c} = 4'hf;
                    fw_c    = 1'b1;
                    state_d = S_MEM_WAIT;
                    cnt_d   = ONE_C;
                end else if (redirectM) begin
                    fd_c = 1'b1;
                    fe_c = 1'b1;
                    fm_c = 1'b1;
                end else if (csr_wr_enE) begin
                    // No stall now: the CSR write must advance into MEM.
                    state_d = S_CSR_DRAIN;
                    cnt_d   = DRAIN_C;
                end else if (lu_hazard) begin
                    sf_c = 1'b1;
                    sd_c = 1'b1;
                    fe_c = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are held low for the whole reset window, whatever the inputs.
    assign dmem_req        = reset & req_c;
    assign stallF          = reset & sf_c;
    assign stallD          = reset & sd_c;
    assign stallE          = reset & se_c;
    assign stallM          = reset & sm_c;
    assign flushD          = reset & fd_c;
    assign flushE          = reset & fe_c;
    assign flushM          = reset & fm_c;
    assign flushW          = reset & fw_c;
    assign mem_timeout_err = reset & err_c;
    assign state_o         = reset ? state_q : 2'd0;

endmodule
